// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and sizing constants for seq_divider.
package div_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int CNT_W = $clog2(DEF_WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division step on the {rem, quo} pair.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);
  logic [WIDTH:0] sh, trial;
  assign sh = {rem, quo[WIDTH-1]};
  assign trial = sh - {1'b0, dvs};
  assign rem_nxt = trial[WIDTH] ? sh[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_nxt = {quo[WIDTH-2:0], ~trial[WIDTH]};
endmodule

// File: rtl/seq_divider.sv
// seq_divider: multicycle signed restoring divider, remainder to HI and quotient to LO.
// Defining SEQ_DIVIDER_DIVU_EN adds the is_unsigned input for DIVU.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
`ifdef SEQ_DIVIDER_DIVU_EN
  input  logic             is_unsigned,
`endif
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             div0
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t state, state_nxt;
  logic [WIDTH-1:0] rem, quo, dvs, rem_nxt, quo_nxt, a_mag, b_mag;
  logic [CW-1:0] cnt;
  logic q_neg, r_neg, uns, go;
`ifdef SEQ_DIVIDER_DIVU_EN
  assign uns = is_unsigned;
`else
  assign uns = 1'b0;
`endif
  // Magnitudes wrap for the most negative value, which still divides correctly as unsigned.
  assign a_mag = (!uns && a_in[WIDTH-1]) ? -a_in : a_in;
  assign b_mag = (!uns && b_in[WIDTH-1]) ? -b_in : b_in;
  assign go = state == IDLE && start;
  assign busy = state != IDLE;
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem(rem),
    .quo(quo),
    .dvs(dvs),
    .rem_nxt(rem_nxt),
    .quo_nxt(quo_nxt)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE ? ((start && |b_in) ? CALC : IDLE) :
                state == CALC ? ((cnt == CW'(1)) ? FIX : CALC) : IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      cnt <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      hi_out <= '0;
      lo_out <= '0;
      done <= 1'b0;
      div0 <= 1'b0;
    end else begin
      done <= state == FIX;
      div0 <= go && ~|b_in;
      if (go && |b_in) begin
        rem <= '0;
        quo <= a_mag;
        dvs <= b_mag;
        cnt <= CW'(WIDTH);
        q_neg <= !uns && (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
        r_neg <= !uns && a_in[WIDTH-1];
      end else if (state == CALC) begin
        rem <= rem_nxt;
        quo <= quo_nxt;
        cnt <= cnt - CW'(1);
      end else if (state == FIX) begin
        lo_out <= q_neg ? -quo : quo;
        hi_out <= r_neg ? -rem : rem;
      end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed vectors with hand-computed MIPS DIV results for seq_divider.
module tb_seq_divider;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [31:0] a_in = '0, b_in = '0;
  logic [31:0] hi_out, lo_out;
  logic busy, done, div0;
  int n_vec = 0, n_err = 0, done_cnt = 0;
`ifdef SEQ_DIVIDER_DIVU_EN
  logic is_unsigned = 1'b0;
`endif
  seq_divider dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .a_in(a_in),
    .b_in(b_in),
`ifdef SEQ_DIVIDER_DIVU_EN
    .is_unsigned(is_unsigned),
`endif
    .hi_out(hi_out),
    .lo_out(lo_out),
    .busy(busy),
    .done(done),
    .div0(div0)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (done) done_cnt++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // Issue one division and check latency, busy length and results.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int k, bc, d0;
    @(negedge clk);
    a_in = a;
    b_in = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    a_in = 32'hDEAD_BEEF;
    b_in = 32'h0000_0003;
    k = 0;
    bc = 0;
    d0 = 0;
    while (!done && k < 50) begin
      if (busy) bc++;
      if (div0) d0++;
      @(posedge clk);
      #1 k++;
    end
    check({tag, " latency"}, k, 33);
    check({tag, " busy_cycles"}, bc, 33);
    check({tag, " lo"}, lo_out, exp_lo);
    check({tag, " hi"}, hi_out, exp_hi);
    check({tag, " div0"}, d0, 0);
    check({tag, " busy_at_done"}, {31'b0, busy}, 0);
    @(posedge clk);
    #1 check({tag, " done_pulse"}, {31'b0, done}, 0);
  endtask
  initial begin
    int dc;
    #1 check("rst hi", hi_out, 0);
    check("rst lo", lo_out, 0);
    check("rst busy", {31'b0, busy}, 0);
    check("rst done", {31'b0, done}, 0);
    check("rst div0", {31'b0, div0}, 0);
    @(negedge clk);
    reset = 1'b1;
    run_div("100/7", 32'd100, 32'd7, 32'd14, 32'd2);
    run_div("-100/7", 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
    run_div("100/-7", 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2);
    run_div("-100/-7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE);
    run_div("7/100", 32'd7, 32'd100, 32'd0, 32'd7);
    run_div("0/5", 32'd0, 32'd5, 32'd0, 32'd0);
    run_div("max/1", 32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 32'd0);
    run_div("-1/2", 32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFF);
    run_div("min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    // Divide by zero: flag for one cycle, no busy, results held.
    @(negedge clk);
    a_in = 32'd5;
    b_in = 32'd0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("div0 pulse", {31'b0, div0}, 1);
    check("div0 busy", {31'b0, busy}, 0);
    @(posedge clk);
    #1 check("div0 clear", {31'b0, div0}, 0);
    check("div0 busy2", {31'b0, busy}, 0);
    check("div0 lo hold", lo_out, 32'h8000_0000);
    check("div0 hi hold", hi_out, 32'd0);
    // Start while busy is ignored.
    @(negedge clk);
    a_in = 32'd100;
    b_in = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 a_in = 32'd1;
    b_in = 32'd1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    k_wait: for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk);
      #1;
    end
    check("busy start done", {31'b0, done}, 1);
    check("busy start lo", lo_out, 32'd14);
    check("busy start hi", hi_out, 32'd2);
    // Reset mid-operation.
    @(negedge clk);
    a_in = 32'd100;
    b_in = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    dc = done_cnt;
    repeat (9) @(posedge clk);
    #1 a_in = 32'd1;
    b_in = 32'd1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #3 check("mid busy", {31'b0, busy}, 1);
    reset = 1'b0;
    #1 check("mid rst hi", hi_out, 0);
    check("mid rst lo", lo_out, 0);
    check("mid rst busy", {31'b0, busy}, 0);
    check("mid rst done", {31'b0, done}, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(posedge clk);
    #1 check("mid no done", done_cnt, dc);
    check("mid post lo", lo_out, 0);
    run_div("after rst", 32'd1000, 32'd10, 32'd100, 32'd0);
`ifdef SEQ_DIVIDER_DIVU_EN
    is_unsigned = 1'b1;
    run_div("divu", 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1);
    is_unsigned = 1'b0;
    run_div("div", 32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFF);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
